truth_table_bist: RTL and testbench

Self-test sequencer for the two-input NAND-built function units in the gate-level labs, for example the ~(~a&b) cell. It drives every input combination into an external combinational unit under test, waits a programmable settle time, and captures each output bit. It then compares the captured truth table against an expected constant and reports pass/fail, the mismatch count and the first failing index. It sits between the bench (or a top-level start switch) and one function unit.

---
 rtl/guia_bist_pkg.sv | 14 +
 rtl/truth_table_bist_if.sv | 24 ++
 rtl/bist_settle_timer.sv | 27 ++
 rtl/truth_table_bist.sv | 101 ++++++++++
 tb/tb_truth_table_bist.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/guia_bist_pkg.sv
// rtl/guia_bist_pkg.sv - shared types and constants for the truth-table self-test sequencer
package guia_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    // Truth table of the ~(~a&b) cell, bit index {a,b}
    localparam logic [3:0] EXP_NOTA_AND_B = 4'b1101;

endpackage

// File: rtl/truth_table_bist_if.sv
// rtl/truth_table_bist_if.sv - start/result bundle between the bench and the self-test sequencer
interface truth_table_bist_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic [N_IN-1:0]        dut_in;
    logic                   dut_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(1<<N_IN)-1:0]   captured;
    logic [N_IN:0]          err_count;
    logic [N_IN-1:0]        first_err_idx;

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, captured, err_count, first_err_idx
    );

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, captured, err_count, first_err_idx
    );
endinterface

// File: rtl/bist_settle_timer.sv
// rtl/bist_settle_timer.sv - clearable counter flagging the end of the settle window
module bist_settle_timer #(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expiry is seen during the last settle cycle so the FSM leaves on that edge
    assign expired = (cnt == CW'(SETTLE_CYC - 1));
endmodule

// File: rtl/truth_table_bist.sv
// rtl/truth_table_bist.sv - sweeps every input vector into an external unit and grades its truth table
module truth_table_bist
    import guia_bist_pkg::*;
#(
    parameter int                   N_IN       = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED   = EXP_NOTA_AND_B,
    parameter int                   SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    truth_table_bist_if.slave bus
);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    bist_state_t            state;
    logic [N_IN-1:0]        dut_in_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [(1<<N_IN)-1:0]   captured_q;
    logic [N_IN:0]          err_q;
    logic [N_IN-1:0]        first_q;

    logic                   expired;
    logic                   mismatch;
    logic [N_IN:0]          err_next;

    assign mismatch = (bus.dut_out != EXPECTED[dut_in_q]);
    assign err_next = err_q + {{N_IN{1'b0}}, mismatch};

    bist_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != SETTLE),
        .count  (state == SETTLE),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
            err_q      <= '0;
            first_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= SETTLE;
                        dut_in_q   <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        captured_q <= '0;
                        err_q      <= '0;
                        first_q    <= '0;
                    end
                end
                SETTLE: begin
                    if (expired) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    captured_q[dut_in_q] <= bus.dut_out;
                    if (mismatch) begin
                        err_q <= err_next;
                        if (err_q == '0) begin
                            first_q <= dut_in_q;
                        end
                    end
                    // The last vector exits to DONE, so dut_in never wraps
                    if (dut_in_q == LAST_VEC) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_next == '0);
                    end else begin
                        state    <= SETTLE;
                        dut_in_q <= dut_in_q + N_IN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dut_in        = dut_in_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.captured      = captured_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_q;
endmodule

// File: tb/tb_truth_table_bist.sv
// tb/tb_truth_table_bist.sv - scoreboard bench for truth_table_bist with default and slow settle instances
module tb_truth_table_bist;

    typedef struct {
        logic [3:0] cap;
        logic [2:0] err;
        logic [1:0] first;
        logic       pass;
        int         lat;
        longint     t_acc;
    } exp_t;

    logic clk;
    logic reset;
    int   mode;
    int   tests;
    int   fails;
    logic prev_a;
    logic prev_b;
    exp_t qa[$];
    exp_t qb[$];

    truth_table_bist_if #(.N_IN(2)) ifa ();
    truth_table_bist_if #(.N_IN(2)) ifb ();

    truth_table_bist #(.N_IN(2), .EXPECTED(4'b1101), .SETTLE_CYC(1)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (ifa.slave)
    );

    truth_table_bist #(.N_IN(2), .EXPECTED(4'b1101), .SETTLE_CYC(3)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (ifb.slave)
    );

    function automatic logic unit_fn(input int m, input logic [1:0] v);
        case (m)
            0:       return ~(~v[1] & v[0]);
            1:       return v[1] & v[0];
            default: return 1'b1;
        endcase
    endfunction

    assign ifa.dut_out = unit_fn(mode, ifa.dut_in);
    assign ifb.dut_out = unit_fn(0, ifb.dut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_result(input string p, input exp_t e, input logic [3:0] cap,
                              input logic [2:0] err, input logic [1:0] first,
                              input logic pass, input logic busy);
        chk({p, "_captured"}, 32'(cap), 32'(e.cap));
        chk({p, "_err_count"}, 32'(err), 32'(e.err));
        if (e.err != 0) chk({p, "_first_err_idx"}, 32'(first), 32'(e.first));
        chk({p, "_pass"}, 32'(pass), 32'(e.pass));
        chk({p, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({p, "_latency"}, 32'(($time - e.t_acc - 5) / 10), 32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_a = 1'b0;
            prev_b = 1'b0;
        end else begin
            if (ifa.done && !prev_a) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_done: got done=1 expected no completion");
                end else begin
                    chk_result("a", qa.pop_front(), ifa.captured, ifa.err_count,
                               ifa.first_err_idx, ifa.pass, ifa.busy);
                end
            end
            if (ifb.done && !prev_b) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected_done: got done=1 expected no completion");
                end else begin
                    chk_result("b", qb.pop_front(), ifb.captured, ifb.err_count,
                               ifb.first_err_idx, ifb.pass, ifb.busy);
                end
            end
            prev_a = ifa.done;
            prev_b = ifb.done;
        end
    end

    function automatic exp_t mk(input logic [3:0] cap, input logic [2:0] err,
                                input logic [1:0] first, input logic pass, input int lat);
        exp_t e;
        e.cap = cap; e.err = err; e.first = first; e.pass = pass; e.lat = lat;
        e.t_acc = longint'($time);
        return e;
    endfunction

    task automatic wait_done_a(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifa.done) begin seen = 1; break; end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL a_done_timeout: got done=0 expected done within %0d cycles", budget);
        end
    endtask

    task automatic run_a(input int m, input logic [3:0] cap, input logic [2:0] err,
                         input logic [1:0] first, input logic pass);
        mode = m;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        qa.push_back(mk(cap, err, first, pass, 8));
        @(negedge clk);
        ifa.start = 1'b0;
        wait_done_a(20);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mode = 0;
        reset = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_dut_in", 32'(k == 0 ? ifa.dut_in : ifb.dut_in), 32'd0);
            chk("reset_flags", 32'(k == 0 ? {ifa.busy, ifa.done, ifa.pass} : {ifb.busy, ifb.done, ifb.pass}), 32'd0);
            chk("reset_results", 32'(k == 0 ? {ifa.captured, ifa.err_count, ifa.first_err_idx}
                                            : {ifb.captured, ifb.err_count, ifb.first_err_idx}), 32'd0);
        end
        reset = 1'b0;

        run_a(0, 4'b1101, 3'd0, 2'd0, 1'b1);
        run_a(1, 4'b1000, 3'd2, 2'd0, 1'b0);
        run_a(2, 4'b1111, 3'd1, 2'd1, 1'b0);

        // start held through the whole sweep must not restart it
        mode = 0;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        qa.push_back(mk(4'b1101, 3'd0, 2'd0, 1'b1, 8));
        @(negedge clk);
        chk("held_busy", 32'(ifa.busy), 32'd1);
        chk("held_done", 32'(ifa.done), 32'd0);
        repeat (6) @(negedge clk);
        ifa.start = 1'b0;
        wait_done_a(20);

        // restart from DONE clears results on the accepting edge
        mode = 2;
        ifa.start = 1'b1;
        @(posedge clk);
        qa.push_back(mk(4'b1111, 3'd1, 2'd1, 1'b0, 8));
        @(negedge clk);
        ifa.start = 1'b0;
        chk("restart_done", 32'(ifa.done), 32'd0);
        chk("restart_busy", 32'(ifa.busy), 32'd1);
        chk("restart_cleared", 32'({ifa.captured, ifa.err_count, ifa.pass}), 32'd0);
        wait_done_a(20);

        // asynchronous reset in the third cycle of a run
        mode = 0;
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        qa.push_back(mk(4'b1101, 3'd0, 2'd0, 1'b1, 8));
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_dut_in", 32'(ifa.dut_in), 32'd0);
        chk("async_rst_flags", 32'({ifa.busy, ifa.done, ifa.pass}), 32'd0);
        chk("async_rst_results", 32'({ifa.captured, ifa.err_count, ifa.first_err_idx}), 32'd0);
        qa.delete();
        @(negedge clk);
        reset = 1'b0;
        run_a(0, 4'b1101, 3'd0, 2'd0, 1'b1);

        // slow settle instance: each vector held four cycles
        @(negedge clk);
        ifb.start = 1'b1;
        @(posedge clk);
        qb.push_back(mk(4'b1101, 3'd0, 2'd0, 1'b1, 16));
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            chk($sformatf("b_hold_%0d", k), 32'(ifb.dut_in), 32'(k / 4));
        end
        repeat (3) @(negedge clk);
        chk("b_done_seen", 32'(ifb.done), 32'd1);

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
